// File: rtl/div_unit_pkg.sv
// div_pkg: shared widths, op encodings, FSM states and special-case results
// for the iterative divide/remainder unit.
package div_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 2;

  // op encoding follows funct3[1:0]; bit 0 = unsigned, bit 1 = remainder
  localparam logic [OP_W-1:0] OP_DIV  = 2'b00;
  localparam logic [OP_W-1:0] OP_DIVU = 2'b01;
  localparam logic [OP_W-1:0] OP_REM  = 2'b10;
  localparam logic [OP_W-1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  localparam logic [XLEN-1:0] QUOT_DIV0  = '1;
  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] NEG_ONE    = '1;

  // Architectural result for divide-by-zero or signed overflow
  function automatic logic [XLEN-1:0] special_result(
    input logic            is_rem,
    input logic            div_zero,
    input logic [XLEN-1:0] dividend
  );
    if (div_zero) begin
      return is_rem ? dividend : QUOT_DIV0;
    end
    return is_rem ? '0 : SIGNED_MIN;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between execute stage and div_unit.
interface div_unit_if;
  import div_pkg::*;

  logic                 start;
  logic [OP_W-1:0]      op;
  logic [REG_W-1:0]     rdIn;
  logic [XLEN-1:0]      dividend;
  logic [XLEN-1:0]      divisor;
  logic                 busy;
  logic                 done;
  logic                 writeEnable;
  logic [REG_W-1:0]     writeReg;
  logic [XLEN-1:0]      writeData;

  modport master (
    output start, op, rdIn, dividend, divisor,
    input  busy, done, writeEnable, writeReg, writeData
  );

  modport slave (
    input  start, op, rdIn, dividend, divisor,
    output busy, done, writeEnable, writeReg, writeData
  );

endinterface

// File: rtl/div_unit_step.sv
// div_step: one radix-2 restoring division iteration (combinational).
module div_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quot_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Shift {rem, quot} left, trial-subtract, keep the difference if non-negative
  always_comb begin
    shifted = {rem, quot[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[XLEN]) begin
      rem_next  = diff[XLEN-1:0];
      quot_next = {quot[XLEN-2:0], 1'b1};
    end else begin
      rem_next  = shifted[XLEN-1:0];
      quot_next = {quot[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU with a registered single-cycle
// register-file write request.
// Build option: define DIV_EARLY_OUT_EN to retire divide-by-zero and signed
// overflow straight from IDLE to DONE.
module div_unit
  import div_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  div_state_e        state_q, state_d;

  logic [OP_W-1:0]   op_q, op_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic [XLEN-1:0]   step_rem, step_quot;

  logic              in_signed, in_div0, in_ovf;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

  div_step u_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .divisor   (dvsr_q),
    .rem_next  (step_rem),
    .quot_next (step_quot)
  );

  // Decode the incoming request: signedness, magnitudes and special cases
  always_comb begin
    in_signed = ~bus.op[0];
    in_div0   = (bus.divisor == '0);
    in_ovf    = in_signed && (bus.dividend == SIGNED_MIN) && (bus.divisor == NEG_ONE);
    abs_a     = (in_signed && bus.dividend[XLEN-1]) ? -bus.dividend : bus.dividend;
    abs_b     = (in_signed && bus.divisor[XLEN-1])  ? -bus.divisor  : bus.divisor;
  end

  // Sign-correct the raw result; special cases take precedence over sign fixes
  always_comb begin
    quot_fix = q_neg_q ? -quot_q : quot_q;
    rem_fix  = r_neg_q ? -rem_q  : rem_q;
    if (div0_q || ovf_q) begin
      fix_result = special_result(op_q[1], div0_q, a_raw_q);
    end else begin
      fix_result = op_q[1] ? rem_fix : quot_fix;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
`ifdef DIV_EARLY_OUT_EN
          state_d = (in_div0 || in_ovf) ? ST_DONE : ST_CALC;
`else
          state_d = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    op_d    = op_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    a_raw_d = a_raw_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          wreg_d  = bus.rdIn;
          a_raw_d = bus.dividend;
          quot_d  = abs_a;
          dvsr_d  = abs_b;
          rem_d   = '0;
          cnt_d   = '0;
          q_neg_d = in_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
          r_neg_d = in_signed && bus.dividend[XLEN-1];
          div0_d  = in_div0;
          ovf_d   = in_ovf;
`ifdef DIV_EARLY_OUT_EN
          if (in_div0 || in_ovf) begin
            wdata_d = special_result(bus.op[1], in_div0, bus.dividend);
          end
`endif
        end
      end
      ST_CALC: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        cnt_d  = cnt_q + 1'b1;
      end
      ST_FIX: begin
        wdata_d = fix_result;
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    we_d   = done_d && (wreg_d != '0);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      a_raw_q <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      op_q    <= op_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      a_raw_q <= a_raw_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.writeEnable = we_q;
  assign bus.writeReg    = wreg_q;
  assign bus.writeData   = wdata_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit against an arithmetic model.
module tb_div_unit;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_unit_if bus();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  // Reference: RISC-V M-extension semantics with plain arithmetic
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    sa = a;
    sb = b;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    if (op == 2'b11 && a == 32'h1 && b == 32'h1) return XLEN + 2;
    return XLEN + 2;
  endfunction

  // Issue one request and wait (bounded) for its completion pulse
  task automatic do_op(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] data, output logic [4:0] wreg, output logic we,
                       output int lat, output int busy_cycles);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.rdIn     = rd;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start   = 1'b0;
    lat         = -1;
    busy_cycles = 0;
    data        = '0;
    wreg        = '0;
    we          = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        lat  = k;
        data = bus.writeData;
        wreg = bus.writeReg;
        we   = bus.writeEnable;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.op       = '0;
    bus.rdIn     = '0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_checks++;
    if (bus.writeEnable !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", bus.writeEnable); end
    n_checks++;
    if (bus.writeReg !== 5'd0) begin n_fail++; $display("FAIL reset_wreg got=%0d exp=0", bus.writeReg); end
    n_checks++;
    if (bus.writeData !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", bus.writeData); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
  endtask

  // Run a table of directed vectors, checking data, write strobe, index and latency
  task automatic run_table(input string name, input vec_t v[]);
    logic [31:0] data;
    logic [4:0]  wreg;
    logic        we;
    int          lat, bc, el;
    foreach (v[i]) begin
      do_op(v[i].op, v[i].rd, v[i].a, v[i].b, data, wreg, we, lat, bc);
      el = exp_latency(v[i].op, v[i].a, v[i].b);
      n_checks++;
      if (lat != el) begin n_fail++; $display("FAIL %s_latency[%0d] got=%0d exp=%0d", name, i, lat, el); end
      n_checks++;
      if (data !== v[i].exp) begin n_fail++; $display("FAIL %s_data[%0d] got=%h exp=%h", name, i, data, v[i].exp); end
      n_checks++;
      if (wreg !== v[i].rd || we !== (v[i].rd != 5'd0)) begin
        n_fail++; $display("FAIL %s_write[%0d] got rd=%0d we=%b exp rd=%0d we=%b", name, i, wreg, we, v[i].rd, v[i].rd != 5'd0);
      end
      n_checks++;
      if (bc != el) begin n_fail++; $display("FAIL %s_busy[%0d] got=%0d exp=%0d", name, i, bc, el); end
    end
  endtask

  task automatic test_basic();
    vec_t v[] = '{
      '{OP_DIVU, 5'd5,  32'd100,        32'd7,          32'd14},
      '{OP_REMU, 5'd5,  32'd100,        32'd7,          32'd2},
      '{OP_DIV,  5'd7,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD},
      '{OP_REM,  5'd8,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF},
      '{OP_DIV,  5'd31, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD}
    };
    run_table("basic", v);
  endtask

  task automatic test_div_zero();
    vec_t v[] = '{
      '{OP_DIVU, 5'd1, 32'd5,         32'd0, 32'hFFFF_FFFF},
      '{OP_REMU, 5'd2, 32'd5,         32'd0, 32'd5},
      '{OP_DIV,  5'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF},
      '{OP_REM,  5'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB}
    };
    run_table("divzero", v);
  endtask

  task automatic test_overflow();
    vec_t v[] = '{
      '{OP_DIV, 5'd10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{OP_REM, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0}
    };
    run_table("overflow", v);
  endtask

  task automatic test_random();
    logic [31:0] a, b, data, exp;
    logic [1:0]  op;
    logic [4:0]  rd, wreg;
    logic        we;
    int          lat, bc, el;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      rd = 5'($urandom_range(1, 31));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        3:       b = 32'($urandom) >> $urandom_range(0, 31);
        default: b = 32'h0;
      endcase
      exp = model(op, a, b);
      el  = exp_latency(op, a, b);
      do_op(op, rd, a, b, data, wreg, we, lat, bc);
      n_checks++;
      if (data !== exp || lat != el || !we || wreg !== rd) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got data=%h lat=%0d we=%b rd=%0d exp data=%h lat=%0d rd=%0d",
                 i, op, a, b, data, lat, we, wreg, exp, el, rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0, d1;
    logic [4:0]  r0, r1;
    logic        w0, w1;
    int          l0, l1, b0, b1;
    do_op(OP_DIVU, 5'd12, 32'hFFFF_FFFF, 32'h10, d0, r0, w0, l0, b0);
    do_op(OP_REM,  5'd13, 32'h7FFF_FFFF, 32'hFFFF_FFFD, d1, r1, w1, l1, b1);
    n_checks++;
    if (d0 !== 32'h0FFF_FFFF || l0 != XLEN + 2) begin
      n_fail++; $display("FAIL b2b_first got=%h lat=%0d exp=0fffffff lat=%0d", d0, l0, XLEN + 2);
    end
    n_checks++;
    if (d1 !== model(OP_REM, 32'h7FFF_FFFF, 32'hFFFF_FFFD) || l1 != XLEN + 2 || r1 !== 5'd13) begin
      n_fail++; $display("FAIL b2b_second got=%h lat=%0d rd=%0d exp=%h lat=%0d rd=13",
                         d1, l1, r1, model(OP_REM, 32'h7FFF_FFFF, 32'hFFFF_FFFD), XLEN + 2);
    end
  endtask

  // rd=0 suppresses the write; starts while busy (incl. DONE cycle) are dropped
  task automatic test_rd_zero_ignored_start();
    int          done_cnt, first_done;
    logic        we_seen;
    logic [31:0] data;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = OP_DIVU;
    bus.rdIn     = 5'd0;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd7;
    @(negedge clk);
    bus.start  = 1'b0;
    done_cnt   = 0;
    first_done = -1;
    we_seen    = 1'b0;
    data       = '0;
    for (int k = 1; k <= XLEN + 2 + 40; k++) begin
      if (bus.done) begin
        done_cnt++;
        if (first_done < 0) begin first_done = k; data = bus.writeData; end
      end
      if (bus.writeEnable) we_seen = 1'b1;
      if (k == 5 || k == XLEN + 2) begin
        bus.start    = 1'b1;
        bus.op       = OP_DIV;
        bus.rdIn     = 5'd9;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL ignored_start_done_count got=%0d exp=1", done_cnt); end
    n_checks++;
    if (first_done != XLEN + 2) begin n_fail++; $display("FAIL rd0_latency got=%0d exp=%0d", first_done, XLEN + 2); end
    n_checks++;
    if (we_seen !== 1'b0) begin n_fail++; $display("FAIL rd0_write_enable got=%b exp=0", we_seen); end
    n_checks++;
    if (data !== 32'd142) begin n_fail++; $display("FAIL rd0_data got=%h exp=%h", data, 32'd142); end
  endtask

  task automatic test_reset_mid();
    int          done_cnt;
    logic [31:0] data;
    logic [4:0]  wreg;
    logic        we;
    int          lat, bc;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = OP_DIVU;
    bus.rdIn     = 5'd4;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got=%b exp=1", bus.busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_after got=%b exp=0", bus.busy); end
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done || bus.writeEnable) done_cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", done_cnt); end
    do_op(OP_DIVU, 5'd3, 32'd9, 32'd3, data, wreg, we, lat, bc);
    n_checks++;
    if (data !== 32'd3 || lat != XLEN + 2 || !we || wreg !== 5'd3) begin
      n_fail++; $display("FAIL midrst_recover got data=%h lat=%0d we=%b rd=%0d exp data=3 lat=%0d we=1 rd=3",
                         data, lat, we, wreg, XLEN + 2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_random();
    test_rd_zero_ignored_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
